ifu_fetch_sequencer: RTL
========================

Name: ifu_fetch_sequencer

Overview:
Multi-cycle sequencer that fronts the instruction fetch unit. It owns the PC, issues requests to an instruction memory with a variable-latency ready handshake, and presents each fetched instruction to the control path with a valid/ready handshake. It resolves the next PC from the branch/zero/jump controls sampled when each instruction is accepted. It also provides halt and fetch-timeout handling so the core can stall cleanly on slow memory.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
WAIT_LIMIT, 16, maximum cycles spent in FETCH without imem_ready before timeout (minimum 1).
CNT_W, 32, width of fetch_count.

Ports:
clock  input  1  system clock; all state updates on the rising edge.
start  input  1  synchronous active-low reset; start==0 at a rising clock edge resets the block.
branch  input  1  current instruction is a conditional branch; sampled on accept.
zero  input  1  ALU zero flag for the current instruction; sampled on accept.
jump  input  1  current instruction is a jump; sampled on accept.
halt  input  1  stop fetching after the current instruction; sampled on accept.
instr_ready  input  1  consumer accepts the instruction this cycle.
imem_ready  input  1  instruction memory has returned data on imem_rdata.
imem_rdata  input  32  instruction word from memory.
imem_req  output  1  fetch request, high only in FETCH.
imem_addr  output  32  fetch address; equals pc.
instr_valid  output  1  instruction output is valid, high only in VALID.
instruction  output  32  registered instruction word.
pc  output  32  address of the instruction being fetched or held.
fetch_count  output  CNT_W  number of accepted instructions.
halted  output  1  high in HALTED.
fetch_timeout  output  1  sticky flag; set when WAIT_LIMIT is exceeded.

Behaviour:
- States: IDLE, FETCH, VALID, HALTED. The state register, pc, instruction, fetch_count, wait counter and fetch_timeout are all flops.
- Reset (start==0 at an edge), from any state including mid-FETCH:
  - state=IDLE, pc=RESET_PC, instruction=0, fetch_count=0, wait counter=0, fetch_timeout=0.
  - All outputs then read 0 except pc/imem_addr, which read RESET_PC.
- IDLE: moves to FETCH on the next edge unconditionally. Exactly one idle cycle follows reset release.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - If imem_ready: instruction<=imem_rdata, wait counter<=0, state<=VALID.
  - Otherwise the wait counter increments. When the counter reaches WAIT_LIMIT-1 with imem_ready still low: fetch_timeout<=1, state<=HALTED.
  - With WAIT_LIMIT=16, a request with no response for 16 consecutive FETCH cycles times out.
- VALID:
  - instr_valid=1; instruction and pc are held stable until accepted.
  - Accept = instr_valid && instr_ready. On accept:
    - fetch_count increments, wrapping modulo 2^CNT_W.
    - pc is updated with priority jump > (branch && zero) > sequential:
      - jump: {pc_plus4[31:28], instruction[25:0], 2'b00}
      - taken branch: pc_plus4 + (signext(instruction[15:0]) << 2)
      - otherwise: pc_plus4
    - pc_plus4 = pc + 4, modulo 2^32. 0xFFFF_FFFC wraps to 0x0000_0000. All target arithmetic is 32-bit and wraps.
    - Next state is HALTED if halt, else FETCH.
  - branch, zero, jump and halt are ignored when no accept occurs.
- HALTED: imem_req=0, instr_valid=0, halted=1. The block leaves HALTED only through reset. pc holds the computed next PC (or the timed-out address).
- Timing:
  - imem_ready is ignored outside FETCH.
  - Zero-wait memory gives 2 cycles per instruction: FETCH, then VALID with instr_ready=1.
  - instr_valid first rises 1 cycle after the imem_ready edge.
- Simultaneous events: reset overrides everything. jump with branch && zero selects the jump target. halt with jump still updates pc before HALTED.

Test Plan:
1. Reset with start=0 for 2 edges, then start=1. Memory is zero-wait returning 0x2002_0005, instr_ready=1, no branch or jump → imem_addr sequence 0x0, 0x4, 0x8, 0xC; instr_valid pulses every 2nd cycle; fetch_count=4 after 4 accepts.
2. At pc=0x10, instruction=0x1000_FFFE, branch=1, zero=1 → next imem_addr=0x0C. Repeat with zero=0 → next imem_addr=0x14.
3. At pc=0x0040_0020, instruction=0x0810_0010, jump=1, branch=1, zero=1 → next imem_addr=0x0040_0040, so jump wins.
4. Memory holds imem_ready low 5 cycles, then high; instr_ready low 3 cycles in VALID → instruction and pc stay stable, fetch_count increments only once, and there is no timeout.
5. imem_ready never asserts with WAIT_LIMIT=16 → fetch_timeout=1 and halted=1 after 16 FETCH cycles; imem_req drops. Then start=0 for one edge → IDLE, pc=RESET_PC, fetch_timeout=0.
6. Accept with halt=1 at pc=0xFFFF_FFFC → pc=0x0000_0000 (wrap), halted=1, and no further imem_req until reset. A second case asserts reset while in FETCH waiting on memory → returns to RESET_PC cleanly, with no spurious instr_valid.

Source files
------------

// File: rtl/ifu_fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, requests words from instruction
// memory, hands them to the control path and resolves the next PC on accept.
module ifu_fetch_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned WAIT_LIMIT = 16,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clock,
  input  logic             start,
  input  logic             branch,
  input  logic             zero,
  input  logic             jump,
  input  logic             halt,
  input  logic             instr_ready,
  input  logic             imem_ready,
  input  logic [31:0]      imem_rdata,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  output logic             instr_valid,
  output logic [31:0]      instruction,
  output logic [31:0]      pc,
  output logic [CNT_W-1:0] fetch_count,
  output logic             halted,
  output logic             fetch_timeout
);

  localparam int unsigned WAIT_W = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_FETCH  = 2'd1;
  localparam logic [1:0] S_VALID  = 2'd2;
  localparam logic [1:0] S_HALTED = 2'd3;

  logic [1:0]        state;
  logic [1:0]        state_nx;
  logic [WAIT_W-1:0] wait_cnt;
  logic              accept_c;
  logic              wait_expired_c;
  logic [31:0]       pc_plus4;
  logic [31:0]       br_off;
  logic [31:0]       pc_next;

  assign imem_addr = pc;

  // State register; start low at an edge returns the sequencer to IDLE.
  always_ff @(posedge clock) begin
    if (!start) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state decode, accept detection and fetch-timeout detection.
  always_comb begin
    state_nx       = state;
    accept_c       = 1'b0;
    wait_expired_c = 1'b0;
    case (state)
      S_IDLE: begin
        state_nx = S_FETCH;
      end
      S_FETCH: begin
        if (imem_ready) begin
          state_nx = S_VALID;
        end else if (wait_cnt == WAIT_W'(WAIT_LIMIT - 1)) begin
          wait_expired_c = 1'b1;
          state_nx       = S_HALTED;
        end
      end
      S_VALID: begin
        if (instr_ready) begin
          accept_c = 1'b1;
          state_nx = halt ? S_HALTED : S_FETCH;
        end
      end
      default: begin
        state_nx = state;
      end
    endcase
  end

  // Next PC: jump wins over a taken branch, which wins over sequential.
  always_comb begin
    pc_plus4 = pc + 32'd4;
    br_off   = {{14{instruction[15]}}, instruction[15:0], 2'b00};
    if (jump) begin
      pc_next = {pc_plus4[31:28], instruction[25:0], 2'b00};
    end else if (branch && zero) begin
      pc_next = pc_plus4 + br_off;
    end else begin
      pc_next = pc_plus4;
    end
  end

  // Datapath registers and registered status outputs decoded from next state.
  always_ff @(posedge clock) begin
    if (!start) begin
      pc            <= RESET_PC;
      instruction   <= '0;
      fetch_count   <= '0;
      wait_cnt      <= '0;
      fetch_timeout <= 1'b0;
      imem_req      <= 1'b0;
      instr_valid   <= 1'b0;
      halted        <= 1'b0;
    end else begin
      imem_req    <= (state_nx == S_FETCH);
      instr_valid <= (state_nx == S_VALID);
      halted      <= (state_nx == S_HALTED);
      if (state == S_FETCH) begin
        if (imem_ready) begin
          instruction <= imem_rdata;
          wait_cnt    <= '0;
        end else if (wait_expired_c) begin
          wait_cnt      <= '0;
          fetch_timeout <= 1'b1;
        end else begin
          wait_cnt <= wait_cnt + WAIT_W'(1);
        end
      end
      if (accept_c) begin
        fetch_count <= fetch_count + CNT_W'(1);
        pc          <= pc_next;
      end
    end
  end

endmodule
